// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the sequenced binary-to-BCD converter.
//   bcd_state_e     - controller state encoding (IDLE/SHIFT/DONE)
//   BCD_ADJ_THRESH  - a digit at or above this gets the add-3 correction
//   BCD_ADJ_ADD     - the correction amount
//   cnt_width()     - width of an iteration counter able to hold WIDTH
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_e;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, purely combinational.
//   din  - one BCD digit before the shift
//   dout - din+3 when din>=5, else din (max result is 12, no wrap)
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;

endmodule

// File: rtl/bcd_conv_ctrl.sv
// bcd_conv_ctrl: sequenced binary-to-BCD converter, one shift-and-add-3
// iteration per clock.
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   - operand handshake, bin is taken in IDLE only
//   bin                 - unsigned operand
//   out_valid/out_ready - result handshake, result held until taken
//   bcd                 - DIGITS packed BCD digits, digit 0 is the units
//   ovf                 - operand did not fit in DIGITS digits
//   busy                - conversion in progress
//   blank               - leading-zero blanking flags (BCD_CONV_LZB_EN only)
// Optional feature macro: BCD_CONV_LZB_EN adds the blank output.
module bcd_conv_ctrl
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf,
`ifdef BCD_CONV_LZB_EN
   output logic [DIGITS-1:0]     blank,
`endif
   output logic                  busy
);

   localparam int AW = 4 * DIGITS;
   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   bcd_state_e state_q, state_d;

   logic [WIDTH-1:0] shreg_q;
   logic [AW-1:0]    acc_q, acc_adj, acc_nxt;
   logic [CW-1:0]    cnt_q;
   logic             accept, shout, last;

   // all digits corrected in parallel before the shift
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (acc_q[4*g +: 4]),
         .dout (acc_adj[4*g +: 4])
      );
   end

   // {acc, shreg} << 1; the bit leaving the acc MSB marks overflow
   assign acc_nxt = {acc_adj[AW-2:0], shreg_q[WIDTH-1]};
   assign shout   = acc_adj[AW-1];
   assign accept  = in_valid & in_ready;
   assign last    = (cnt_q == CNT_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef BCD_CONV_LZB_EN
   // blank[i]: digit i and everything above it are zero; units never blank
   logic [DIGITS-1:0] blank_nxt;
   logic              hz;

   always_comb begin
      blank_nxt = '0;
      hz        = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         hz           = hz & (acc_nxt[4*i +: 4] == 4'd0);
         blank_nxt[i] = hz;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        blank <= {{(DIGITS-1){1'b1}}, 1'b0};
      else if (state_q == SHIFT && last) blank <= blank_nxt;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bcd     <= '0;
         ovf     <= 1'b0;
      end else if (accept) begin
         shreg_q <= bin;
         acc_q   <= '0;
         cnt_q   <= CNT_INIT;
         ovf     <= 1'b0;
      end else if (state_q == SHIFT) begin
         shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
         acc_q   <= acc_nxt;
         cnt_q   <= cnt_q - CNT_ONE;
         ovf     <= ovf | shout;
         // bcd keeps the previous result until the final shift lands
         if (last) bcd <= acc_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// tb_bcd_conv_ctrl: two converters (5 and 4 digits) share one stimulus
// stream; expected results come from decimal arithmetic on the operand.
module tb_bcd_conv_ctrl;

   localparam int W = 16;

   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [15:0] bin = '0;
   logic        in_ready5, out_valid5, busy5, ovf5;
   logic        in_ready4, out_valid4, busy4, ovf4;
   logic [19:0] bcd5;
   logic [15:0] bcd4;
`ifdef BCD_CONV_LZB_EN
   logic [4:0]  blank5;
   logic [3:0]  blank4;
`endif

   always #5 clk = ~clk;

   bcd_conv_ctrl #(.WIDTH(W), .DIGITS(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
      .bin(bin), .out_valid(out_valid5), .out_ready(out_ready), .bcd(bcd5),
      .ovf(ovf5),
`ifdef BCD_CONV_LZB_EN
      .blank(blank5),
`endif
      .busy(busy5));

   bcd_conv_ctrl #(.WIDTH(W), .DIGITS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .bin(bin), .out_valid(out_valid4), .out_ready(out_ready), .bcd(bcd4),
      .ovf(ovf4),
`ifdef BCD_CONV_LZB_EN
      .blank(blank4),
`endif
      .busy(busy4));

   typedef struct {
      logic [19:0] b5;
      logic        o5;
      logic [15:0] b4;
      logic        o4;
      logic [4:0]  bl5;
      logic [3:0]  bl4;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0, n_fail = 0, cyc = 0;
   bit   rand_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // decimal digits of v; blank[i] set when the truncated value is below 10^i
   function automatic exp_t model(input int unsigned v, input int acc);
      exp_t        e;
      int unsigned t = v;
      int unsigned p = 1;
      e.b5 = '0;
      for (int d = 0; d < 5; d++) begin
         e.b5[4*d +: 4] = 4'(t % 10);
         t = t / 10;
      end
      e.b4 = e.b5[15:0];
      e.o5 = (v > 99999);
      e.o4 = (v > 9999);
      for (int i = 0; i < 5; i++) begin
         e.bl5[i] = (i > 0) && ((v % 100000) < p);
         if (i < 4) e.bl4[i] = (i > 0) && ((v % 10000) < p);
         p = p * 10;
      end
      e.acc = acc;
      return e;
   endfunction

   // drive one operand; it is accepted at the first edge with in_ready high
   task automatic send(input logic [15:0] v);
      int n = 0;
      @(posedge clk); #1;
      bin = v;
      in_valid = 1'b1;
      while (!in_ready5 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready5) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout: in_ready stuck low for bin %0d", v);
         in_valid = 1'b0;
      end else begin
         q.push_back(model(v, cyc + 1));
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // monitor: checks every cycle a result is presented, pops on handshake
   bit prev_ov = 1'b0;
   int rise = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid5 && !prev_ov) rise = cyc;
         prev_ov = out_valid5;
         chk("in_ready_idle_only", {31'd0, in_ready5}, {31'd0, !(busy5 || out_valid5)});
         if (out_valid5) begin
            if (q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL unexpected_out_valid: got bcd %h expected no result", bcd5);
            end else begin
               chk("bcd5", {12'd0, bcd5}, {12'd0, q[0].b5});
               chk("ovf5", {31'd0, ovf5}, {31'd0, q[0].o5});
               chk("out_valid4", {31'd0, out_valid4}, 32'd1);
               chk("bcd4", {16'd0, bcd4}, {16'd0, q[0].b4});
               chk("ovf4", {31'd0, ovf4}, {31'd0, q[0].o4});
`ifdef BCD_CONV_LZB_EN
               chk("blank5", {27'd0, blank5}, {27'd0, q[0].bl5});
               chk("blank4", {28'd0, blank4}, {28'd0, q[0].bl4});
`endif
               if (out_ready) begin
                  chk("latency", 32'(rise - q[0].acc), 32'(W));
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   task automatic chk_reset_vals();
      chk("rst_in_ready", {30'd0, in_ready5, in_ready4}, 32'd3);
      chk("rst_out_valid", {30'd0, out_valid5, out_valid4}, 32'd0);
      chk("rst_busy", {30'd0, busy5, busy4}, 32'd0);
      chk("rst_bcd", {12'd0, bcd5}, 32'd0);
      chk("rst_bcd4", {16'd0, bcd4}, 32'd0);
      chk("rst_ovf", {30'd0, ovf5, ovf4}, 32'd0);
`ifdef BCD_CONV_LZB_EN
      chk("rst_blank5", {27'd0, blank5}, 32'h1e);
      chk("rst_blank4", {28'd0, blank4}, 32'he);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      #12;
      chk_reset_vals();
      @(posedge clk); #1;
      rst_n = 1'b1;

      send(16'd0);
      send(16'd65535);
      send(16'd9);
      send(16'd12345);
      send(16'd9999);
      send(16'd305);

      // result held while out_ready is low; new operands ignored meanwhile
      send(16'd4321);
      out_ready = 1'b0;
      n = 0;
      while (!out_valid5 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("hold_reach_done", {31'd0, out_valid5}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         bin = 16'd1234;
         in_valid = 1'b1;
         chk("hold_in_ready", {31'd0, in_ready5}, 32'd0);
         chk("hold_out_valid", {31'd0, out_valid5}, 32'd1);
         chk("hold_bcd", {12'd0, bcd5}, 32'h04321);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;

      // asynchronous reset partway through a conversion
      send(16'd999);
      repeat (6) @(posedge clk);
      chk("busy_before_rst", {31'd0, busy5}, 32'd1);
      #3;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk_reset_vals();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      send(16'd7);

      // randomized operands with random consumer back-pressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 30; i++) send(16'($urandom_range(0, 65535)));
      send(16'd10000);
      send(16'd100);
      rand_rdy = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;

      n = 0;
      while (q.size() > 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (q.size() > 0) begin
         n_cmp++; n_fail++;
         $display("FAIL drain: %0d results outstanding, expected 0", q.size());
      end
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
